// File: rtl/cnn_pkg.sv
// Shared definitions for the 28x28 CNN pipeline: image geometry, pixel type, streamer states.
package cnn_pkg;

   localparam int unsigned IMG_W = 28;
   localparam int unsigned IMG_H = 28;
   localparam int unsigned PIX_W = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARM       = 2'd1,
      STREAM    = 2'd2,
      WAIT_DONE = 2'd3
   } stream_state_e;

endpackage

// File: rtl/image_streamer_if.sv
// Host write port plus engine start/pixel/done handshake of the image streamer.
interface image_streamer_if #(
   parameter int unsigned PIX_W = 8
);

   logic             wr_valid;
   logic [PIX_W-1:0] wr_data;
   logic             wr_ready;
   logic             conv_start;
   logic [PIX_W-1:0] pixel_out;
   logic             conv_done;

   // master = host + engine side, slave = streamer
   modport master (
      output wr_valid, wr_data, conv_done,
      input  wr_ready, conv_start, pixel_out
   );

   modport slave (
      input  wr_valid, wr_data, conv_done,
      output wr_ready, conv_start, pixel_out
   );

endinterface

// File: rtl/frame_ram.sv
// Single-frame buffer: one write port, one read port with 1-cycle latency.
module frame_ram #(
   parameter int unsigned DEPTH = 784,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register returns 0 on cycles without a read so the consumer sees a gated stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
      else         rdata <= '0;
   end

endmodule

// File: rtl/image_streamer.sv
// Buffers one host frame, then streams it to the conv engine and waits for its done pulse.
module image_streamer #(
   parameter int unsigned IMG_W        = cnn_pkg::IMG_W,
   parameter int unsigned IMG_H        = cnn_pkg::IMG_H,
   parameter int unsigned PIX_W        = cnn_pkg::PIX_W,
   parameter int unsigned DONE_TIMEOUT = 4096
) (
   input  logic            clk,
   input  logic            rst_n,
   image_streamer_if.slave bus,
   output logic            busy,
   output logic            frame_done,
   output logic            timeout_err
);
   import cnn_pkg::*;

   localparam int unsigned N  = IMG_W * IMG_H;
   localparam int unsigned AW = $clog2(N);
   localparam int unsigned TW = $clog2(DONE_TIMEOUT);

   stream_state_e state, state_n;

   logic [AW-1:0] wptr, rptr, raddr_c;
   logic [TW-1:0] tcnt;
   logic          wr_fire_c, last_wr_c, last_rd_c, tmo_c, re_c;

   assign wr_fire_c = bus.wr_valid && bus.wr_ready;
   assign last_wr_c = wr_fire_c && (wptr == AW'(N - 1));
   assign last_rd_c = (state == STREAM) && (rptr == AW'(N - 1));
   // conv_done takes priority over the timeout terminal count
   assign tmo_c     = (state == WAIT_DONE) && !bus.conv_done &&
                      (tcnt == TW'(DONE_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      re_c    = 1'b0;
      raddr_c = '0;
      case (state)
         IDLE: begin
            if (last_wr_c) state_n = ARM;
         end
         ARM: begin
            re_c    = 1'b1;
            state_n = STREAM;
         end
         STREAM: begin
            // reads run one address ahead of the STREAM cycle index
            if (last_rd_c) begin
               state_n = WAIT_DONE;
            end else begin
               re_c    = 1'b1;
               raddr_c = rptr + AW'(1);
            end
         end
         WAIT_DONE: begin
            if (bus.conv_done || tmo_c) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         tcnt <= '0;
      end else begin
         if (wr_fire_c) wptr <= last_wr_c ? '0 : wptr + AW'(1);
         if (state == STREAM) rptr <= last_rd_c ? '0 : rptr + AW'(1);
         else                 rptr <= '0;
         if (state == WAIT_DONE) tcnt <= tcnt + TW'(1);
         else                    tcnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wr_ready   <= 1'b0;
         bus.conv_start <= 1'b0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         bus.wr_ready   <= (state_n == IDLE);
         bus.conv_start <= (state_n == ARM);
         busy           <= (state_n != IDLE);
         frame_done     <= (state == WAIT_DONE) && bus.conv_done;
         timeout_err    <= timeout_err | tmo_c;
      end
   end

   frame_ram #(
      .DEPTH (N),
      .WIDTH (PIX_W)
   ) u_frame_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_fire_c),
      .waddr (wptr),
      .wdata (bus.wr_data),
      .re    (re_c),
      .raddr (raddr_c),
      .rdata (bus.pixel_out)
   );

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench: two streamers (default and short timeout) fed the same host and done stimulus.
module tb_image_streamer;
   import cnn_pkg::*;

   localparam int N = 784;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   wr_valid = 1'b0;
   pixel_t wr_data = '0;
   logic   conv_done = 1'b0;

   logic busy_a, frame_done_a, timeout_err_a;
   logic busy_b, frame_done_b, timeout_err_b;

   int n_chk = 0;
   int n_pass = 0;
   int fd_b_cnt = 0;

   image_streamer_if #(.PIX_W(8)) bus_a ();
   image_streamer_if #(.PIX_W(8)) bus_b ();

   assign bus_a.wr_valid  = wr_valid;
   assign bus_a.wr_data   = wr_data;
   assign bus_a.conv_done = conv_done;
   assign bus_b.wr_valid  = wr_valid;
   assign bus_b.wr_data   = wr_data;
   assign bus_b.conv_done = conv_done;

   image_streamer u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_a),
      .busy        (busy_a),
      .frame_done  (frame_done_a),
      .timeout_err (timeout_err_a)
   );

   image_streamer #(.DONE_TIMEOUT(64)) u_dut_to (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_b),
      .busy        (busy_b),
      .frame_done  (frame_done_b),
      .timeout_err (timeout_err_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (frame_done_b) fd_b_cnt <= fd_b_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic pixel_t pat(input int mode, input int k);
      case (mode)
         0:       return 8'(k);
         1:       return 8'(k * 7 + 3);
         default: return 8'(255 - k);
      endcase
   endfunction

   // Writes pat(mode,k) for k in [lo,hi); returns at the negedge after the last accepting edge.
   task automatic write_range(input int lo, input int hi, input int mode, input bit gaps);
      for (int k = lo; k < hi; k++) begin
         int guard;
         if (gaps && (k % 2 == 1)) begin
            wr_valid = 1'b0;
            @(negedge clk);
         end
         wr_valid = 1'b1;
         wr_data  = pat(mode, k);
         guard    = 0;
         while (!bus_a.wr_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 3000) begin
            chk("wr_ready_wait", 32'(bus_a.wr_ready), 1);
            wr_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      wr_valid = 1'b0;
   endtask

   // Called in the conv_start cycle; checks pixels k=0..N-1 (or up to stop_at) and the zero tail.
   task automatic check_stream(input int mode, input int stop_at);
      chk("conv_start_a", 32'(bus_a.conv_start), 1);
      chk("conv_start_b", 32'(bus_b.conv_start), 1);
      chk("wr_ready_low", 32'(bus_a.wr_ready), 0);
      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         if (k == 0) chk("start_one_cycle", 32'(bus_a.conv_start), 0);
         chk($sformatf("pix_a[%0d]", k), 32'(bus_a.pixel_out), 32'(pat(mode, k)));
         chk($sformatf("pix_b[%0d]", k), 32'(bus_b.pixel_out), 32'(pat(mode, k)));
         if (k == stop_at) return;
      end
      @(negedge clk);
      chk("pix_tail_a", 32'(bus_a.pixel_out), 0);
      chk("pix_tail_b", 32'(bus_b.pixel_out), 0);
      chk("busy_wait_a", 32'(busy_a), 1);
   endtask

   task automatic pulse_done_expect(input bit exp_fd);
      conv_done = 1'b1;
      @(negedge clk);
      conv_done = 1'b0;
      chk("frame_done_a", 32'(frame_done_a), 32'(exp_fd));
      if (exp_fd) begin
         chk("busy_after_done", 32'(busy_a), 0);
         chk("wr_ready_after_done", 32'(bus_a.wr_ready), 1);
      end
      @(negedge clk);
      chk("frame_done_one_cycle", 32'(frame_done_a), 0);
   endtask

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      chk("rst_wr_ready", 32'(bus_a.wr_ready), 0);
      chk("rst_conv_start", 32'(bus_a.conv_start), 0);
      chk("rst_pixel_out", 32'(bus_a.pixel_out), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_frame_done", 32'(frame_done_a), 0);
      chk("rst_timeout_err", 32'(timeout_err_b), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("wr_ready_rise", 32'(bus_a.wr_ready), 1);

      // conv_done in IDLE is ignored
      pulse_done_expect(1'b0);

      // frame 1: back-to-back, wr_valid held high during the stream
      write_range(0, N, 0, 1'b0);
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      check_stream(0, -1);
      wr_valid = 1'b0;

      // short-timeout instance: 64 WAIT_DONE cycles then error
      repeat (63) @(negedge clk);
      chk("tmo_b_before", 32'(timeout_err_b), 0);
      chk("busy_b_before", 32'(busy_b), 1);
      @(negedge clk);
      chk("tmo_b_set", 32'(timeout_err_b), 1);
      chk("busy_b_idle", 32'(busy_b), 0);
      chk("wr_ready_b_idle", 32'(bus_b.wr_ready), 1);

      // default instance: done 1000 cycles after the stream
      repeat (1000 - 65) @(negedge clk);
      chk("no_early_frame_done", 32'(frame_done_a), 0);
      chk("busy_a_waiting", 32'(busy_a), 1);
      chk("tmo_a_clear", 32'(timeout_err_a), 0);
      pulse_done_expect(1'b1);

      // frame 2: gapped host writes, next frame accepted right after frame_done
      write_range(0, N, 1, 1'b1);
      chk("tmo_b_sticky", 32'(timeout_err_b), 1);
      check_stream(1, -1);
      repeat (64) @(negedge clk);
      chk("tmo_b_after_frame2", 32'(timeout_err_b), 1);
      chk("tmo_a_after_frame2", 32'(timeout_err_a), 0);
      pulse_done_expect(1'b1);

      // frame 3: reset at stream pixel 300
      write_range(0, N, 2, 1'b0);
      check_stream(2, 300);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pixel", 32'(bus_a.pixel_out), 0);
      chk("mid_rst_start", 32'(bus_a.conv_start), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_wr_ready", 32'(bus_a.wr_ready), 0);
      chk("mid_rst_tmo_b", 32'(timeout_err_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus_a.wr_ready), 1);

      // partial frame, then reset discards it
      write_range(0, 400, 2, 1'b0);
      chk("partial_idle", 32'(busy_a), 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 783 pixels must not start the engine; the 784th does
      write_range(0, N - 1, 0, 1'b1);
      repeat (3) @(negedge clk);
      chk("no_start_783", 32'(busy_a), 0);
      chk("no_conv_start_783", 32'(bus_a.conv_start), 0);
      write_range(N - 1, N, 0, 1'b0);
      check_stream(0, -1);

      chk("fd_b_pulses", 32'(fd_b_cnt), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
